adc_spi_responder: RTL

//   Synthesizable responder (slave) side of the 8-channel 12-bit ADC serial link that adc_polling drives.

---
 rtl/adc_spi_pkg.sv | 18 +
 rtl/adc_spi_responder_sync_edge.sv | 32 +++
 rtl/adc_spi_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/adc_spi_pkg.sv
// Shared constants and state encoding for the 8-channel 12-bit ADC serial link.
// Used by the responder RTL and by benches that drive the master side.
package adc_spi_pkg;

  localparam int FRAME_BITS   = 16;
  localparam int DATA_BITS    = 12;
  localparam int NUM_CH       = 8;
  localparam int CTRL_BITS    = 8;
  localparam int ADDR_LSB_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus 1-clk rise/fall
// strobes derived from the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC emulator on the slave side of the serial link: decodes the channel
// address from din and shifts the selected 12-bit value out on dout.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] FIRST_ADDR  = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sclk,
  input  logic        din,
  input  logic [95:0] ch_values,
  output logic        dout,
  output logic        frame_done,
  output logic [2:0]  last_addr,
  output logic        busy
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
  localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] CTRL_CNT = 5'(CTRL_BITS);
  localparam int         ADD_MSB  = CTRL_BITS - 1 - ADDR_LSB_BIT;

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_din_lvl, w_din_rise, w_din_fall;
  logic w_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .i_d(cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .i_d(sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk(clk), .rst(rst), .i_d(din),
    .o_level(w_din_lvl), .o_rise(w_din_rise), .o_fall(w_din_fall)
  );

  assign w_unused = &{1'b0, w_sclk_lvl, w_din_rise, w_din_fall};

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CTRL_BITS-1:0]  r_ctrl;
  logic [4:0]            r_bit_cnt;
  logic [2:0]            r_next_addr;
  logic [2:0]            r_last_addr;
  logic                  r_dout;
  logic                  r_done;
  logic                  r_busy;
  logic [2:0]            w_add;
  logic [DATA_BITS-1:0]  w_sel;

  // Control bits shift in MSB-first, so the first bit ends up at the top.
  assign w_add = r_ctrl[ADD_MSB -: 3];
  assign w_sel = ch_values[DATA_BITS*r_next_addr +: DATA_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_ctrl      <= '0;
      r_bit_cnt   <= '0;
      r_next_addr <= FIRST_ADDR;
      r_last_addr <= '0;
      r_dout      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_dout <= 1'b0;
          r_busy <= 1'b0;
          if (w_cs_fall) r_state <= LOAD;
        end
        LOAD: begin
          r_shift   <= {{(FRAME_BITS-DATA_BITS){1'b0}}, w_sel};
          r_ctrl    <= '0;
          r_bit_cnt <= '0;
          r_dout    <= 1'b0;
          r_busy    <= 1'b1;
          r_state   <= SHIFT;
          if (w_cs_rise) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (w_sclk_rise && r_bit_cnt != FULL_CNT) begin
            if (r_bit_cnt < CTRL_CNT)
              r_ctrl <= {r_ctrl[CTRL_BITS-2:0], w_din_lvl};
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
          if (w_sclk_fall && r_bit_cnt != 5'd0 && r_bit_cnt != FULL_CNT) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            r_dout  <= r_shift[FRAME_BITS-2];
          end
          // A 16th rise completes the frame even if cs rises in the same clk.
          if (w_sclk_rise && r_bit_cnt == LAST_BIT) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_next_addr <= w_add;
            r_last_addr <= w_add;
          end else if (w_cs_rise) begin
            r_state <= IDLE;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          if (w_cs_lvl) begin
            r_state <= IDLE;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= LOAD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign frame_done = r_done;
  assign last_addr  = r_last_addr;
  assign busy       = r_busy;

endmodule
